// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: converts the CPU valid/ready memory port into single-strobe request/ack bus cycles.
// Optional watchdog abort of hung accesses is compiled in when CPU_BUS_TIMEOUT_EN is defined.
module cpu_bus_bridge #(
    parameter int NUM_DEVICES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        bus_request_o,
    input  logic        bus_ack_i,
    output logic [3:0]  bus_wmask_o,
    output logic [31:0] bus_address_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    output logic        err_pending_o,
    output logic        err_timeout_o,
    output logic [31:0] err_address_o,
    input  logic        err_clear_i
);

    if (NUM_DEVICES < 1 || NUM_DEVICES > 16) begin : g_bad_num_devices
        $error("cpu_bus_bridge: NUM_DEVICES must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cpu_bus_bridge: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_pending_q, err_pending_d;
    logic        err_timeout_q, err_timeout_d;
    logic [31:0] err_address_q, err_address_d;

    logic        unmapped;
    logic        timeout_hit;
    logic        error_event;
    logic        error_is_timeout;

    assign unmapped = ({1'b0, mem_addr_i[31:28]} >= 5'(NUM_DEVICES));

`ifdef CPU_BUS_TIMEOUT_EN
    // Counter holds (cycles since REQ - 1) while in WAIT; expiry is decided one
    // cycle before RESP so mem_ready lands exactly TIMEOUT_CYCLES after REQ.
    localparam logic [15:0] EXPIRE_AT = 16'(TIMEOUT_CYCLES - 2);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == REQ) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = ((state_q == REQ) && (TIMEOUT_CYCLES == 1)) ||
                         ((state_q == WAIT) && (cnt_q == EXPIRE_AT));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        rdata_d          = rdata_q;
        error_event      = 1'b0;
        error_is_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wmask_d = mem_wstrb_i;
                    if (unmapped) begin
                        rdata_d     = '0;
                        error_event = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            // An ack in the expiry cycle takes priority over the timeout.
            REQ, WAIT: begin
                if (bus_ack_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d          = '0;
                    error_event      = 1'b1;
                    error_is_timeout = 1'b1;
                    state_d          = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A new error overrides a simultaneous clear; otherwise the first error sticks.
    always_comb begin
        err_pending_d = err_pending_q;
        err_timeout_d = err_timeout_q;
        err_address_d = err_address_q;
        if (error_event && (!err_pending_q || err_clear_i)) begin
            err_pending_d = 1'b1;
            err_timeout_d = error_is_timeout;
            err_address_d = addr_d;
        end else if (err_clear_i) begin
            err_pending_d = 1'b0;
            err_timeout_d = 1'b0;
            err_address_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            rdata_q       <= '0;
            err_pending_q <= 1'b0;
            err_timeout_q <= 1'b0;
            err_address_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            rdata_q       <= rdata_d;
            err_pending_q <= err_pending_d;
            err_timeout_q <= err_timeout_d;
            err_address_q <= err_address_d;
        end
    end

    assign mem_ready_o   = (state_q == RESP);
    assign mem_rdata_o   = mem_ready_o ? rdata_q : 32'h0000_0000;
    assign bus_request_o = (state_q == REQ);
    assign bus_address_o = addr_q;
    assign bus_wdata_o   = wdata_q;
    assign bus_wmask_o   = wmask_q;
    assign err_pending_o = err_pending_q;
`ifdef CPU_BUS_TIMEOUT_EN
    assign err_timeout_o = err_timeout_q;
`else
    assign err_timeout_o = 1'b0;
`endif
    assign err_address_o = err_address_q;

endmodule
